// File: rtl/rptr_empty_fwft.sv
// rptr_empty_fwft: read pointer, empty/almost-empty flags and FWFT output
// register for the read side of an asynchronous FIFO.
// Optional feature macro: RLEVEL_EN (registered memory fill level on rlevel).
module rptr_empty_fwft #(
    parameter int ADDRSIZE = 4,
    parameter int DSIZE    = 8
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DSIZE-1:0]    rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                arempty,
    output logic [DSIZE-1:0]    dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [ADDRSIZE:0]   rlevel
);

    localparam logic [ADDRSIZE:0] ONE = {{ADDRSIZE{1'b0}}, 1'b1};

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rbinnextp1;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] rgraynextp1;
    logic              pop;

    // A word moves into dout whenever memory has one and dout is free or
    // being drained this cycle; this is what advances the read pointer.
    assign pop         = ~rempty & (~dout_valid | dout_ready);
    assign rbinnext    = rbin + (pop ? ONE : '0);
    assign rbinnextp1  = rbinnext + ONE;
    assign rgraynext   = (rbinnext >> 1) ^ rbinnext;
    assign rgraynextp1 = (rbinnextp1 >> 1) ^ rbinnextp1;
    assign raddr       = rbin[ADDRSIZE-1:0];

    // Pointer registers and flags, all computed from the next-state pointer
    // so the flags line up with the pointer they describe.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            arempty <= 1'b1;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == rq2_wptr);
            arempty <= (rgraynext == rq2_wptr) | (rgraynextp1 == rq2_wptr);
        end
    end

    // FWFT output register: refill on pop (no bubble on accept+refill),
    // otherwise drop valid when the consumer takes the word.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (pop) begin
            dout       <= rdata;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

`ifdef RLEVEL_EN
    logic [ADDRSIZE:0] wbin;

    // Gray-to-binary of the synchronized write pointer: bit i is the XOR of
    // all Gray bits at or above i.
    for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_g2b
        assign wbin[i] = ^(rq2_wptr >> i);
    end

    // Fill level uses the next read pointer so it is aligned with rempty.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) rlevel <= '0;
        else         rlevel <= wbin - rbinnext;
    end
`else
    assign rlevel = '0;
`endif

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Randomized bench for rptr_empty_fwft (ADDRSIZE=4, DSIZE=8) against an
// occupancy-count reference model plus an in-order word scoreboard.
module tb_rptr_empty_fwft;

    logic       rclk = 1'b0;
    logic       rrst_n = 1'b0;
    logic [4:0] rq2_wptr;
    logic [7:0] rdata;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty, arempty;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic [4:0] rlevel;

    always #5 rclk = ~rclk;

    rptr_empty_fwft #(.ADDRSIZE(4), .DSIZE(8)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .rdata(rdata),
        .raddr(raddr), .rptr(rptr), .rempty(rempty), .arempty(arempty),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .rlevel(rlevel)
    );

    // Memory and writer side, owned by the bench
    logic [7:0]  mem [16];
    logic [31:0] wcnt = 0;
    logic [7:0]  expq [$];

    function automatic logic [4:0] g5(input logic [31:0] b);
        return b[4:0] ^ (b[4:0] >> 1);
    endfunction

    assign rq2_wptr = g5(wcnt);
    assign rdata    = mem[raddr];

    // Reference model: words popped, dout register, flags from occupancy
    logic [31:0] rd = 0;
    logic [31:0] mlevel = 0;
    bit          mvalid = 0, mempty = 1, maempty = 1;
    logic [7:0]  mdata = 0;
    bit          wrap_seen = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        if (wcnt - rd < 16) begin
            mem[wcnt[3:0]] = v;
            expq.push_back(v);
            wcnt = wcnt + 1;
        end
    endtask

    task automatic check_outs();
        chk("rempty", rempty, mempty);
        chk("arempty", arempty, maempty);
        chk("dout_valid", dout_valid, mvalid);
        chk("dout", dout, mdata);
        chk("rptr", rptr, g5(rd));
        chk("raddr", raddr, rd[3:0]);
        chk("rlevel", rlevel, mlevel);
    endtask

    // One clock: scoreboard accept, advance model, then compare at negedge
    task automatic step(input bit rdy);
        bit         pop;
        logic [4:0] prev;
        logic [31:0] occ;
        dout_ready = rdy;
        if (dout_valid && rdy) begin
            if (expq.size() == 0) chk("accept_extra", 1, 0);
            else                  chk("accept", dout, expq.pop_front());
        end
        prev = rptr;
        pop  = !mempty && (!mvalid || rdy);
        if (pop) begin
            mdata  = mem[rd[3:0]];
            mvalid = 1;
            rd     = rd + 1;
        end else if (rdy) begin
            mvalid = 0;
        end
        occ     = wcnt - rd;
        mempty  = (occ == 0);
        maempty = (occ <= 1);
`ifdef RLEVEL_EN
        mlevel  = occ;
`else
        mlevel  = 0;
`endif
        @(posedge rclk);
        @(negedge rclk);
        check_outs();
        chk("rptr_1bit", $countones(rptr ^ prev) <= 1, 1);
        if (prev == 5'h10 && rptr == 5'h00) wrap_seen = 1;
    endtask

    task automatic do_reset();
        #2 rrst_n = 1'b0;
        #1;
        chk("rst_rempty", rempty, 1);
        chk("rst_arempty", arempty, 1);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_rptr", rptr, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_rlevel", rlevel, 0);
        chk("rst_dout", dout, 0);
        rd = 0; wcnt = 0; mvalid = 0; mempty = 1; maempty = 1;
        mdata = 0; mlevel = 0;
        expq.delete();
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && !(mempty && !mvalid); i++) step(1);
        step(1);
        chk("drain_valid", dout_valid, 0);
        chk("drain_q", expq.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        @(negedge rclk);
        do_reset();

        // Single word with consumer stalled
        push(8'hA5);
        step(0);
        chk("sw_rempty_t1", rempty, 0);
        step(0);
        chk("sw_dout", dout, 8'hA5);
        chk("sw_valid", dout_valid, 1);
        chk("sw_rptr", rptr, 1);
        chk("sw_rempty_t2", rempty, 1);
        for (int i = 0; i < 3; i++) begin
            step(0);
            chk("sw_hold", dout, 8'hA5);
        end
        // Reset with a word held in dout
        do_reset();

        // Streaming 16 words at full rate
        for (int i = 0; i < 16; i++) push(i[7:0]);
        step(1);
        chk("st_rempty_t1", rempty, 0);
        for (int i = 0; i < 16; i++) begin
            step(1);
            chk("st_valid", dout_valid, 1);
            chk("st_dout", dout, i);
            if (i == 14) chk("st_raddr15", raddr, 15);
        end
        chk("st_raddr_wrap", raddr, 0);
        chk("st_rptr", rptr, 5'h18);
        chk("st_rempty_end", rempty, 1);
        drain();

        // Backpressure pattern
        for (int i = 0; i < 3; i++) push($urandom);
        step(1); step(0); step(0); step(1); step(1);
        drain();

        // 40 words through with random traffic, crossing pointer wrap
        begin
            int written = 0;
            for (int c = 0; c < 2000 && written < 40; c++) begin
                if ($urandom_range(0, 1) == 1 && wcnt - rd < 16) begin
                    push($urandom);
                    written++;
                end
                step($urandom_range(0, 3) != 0);
            end
            chk("wrap_written", written, 40);
            drain();
            chk("wrap_seen", wrap_seen, 1);
        end

        // Random phase with a mid-stream reset
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            if ($urandom_range(0, 2) != 0) push($urandom);
            step($urandom_range(0, 3) != 0);
        end
        drain();

        // Fill-level check
        do_reset();
        for (int i = 0; i < 5; i++) push($urandom);
        step(0);
        chk("lv_arempty5", arempty, 0);
`ifdef RLEVEL_EN
        chk("lv_rlevel5", rlevel, 5);
`else
        chk("lv_rlevel5", rlevel, 0);
`endif
        step(0); step(1); step(1); step(1);
        chk("lv_arempty1", arempty, 1);
        chk("lv_rempty1", rempty, 0);
`ifdef RLEVEL_EN
        chk("lv_rlevel1", rlevel, 1);
`else
        chk("lv_rlevel1", rlevel, 0);
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
